// File: rtl/on_chip_mem_burst_reader_if.sv
// Capture-RAM read port plus the outgoing sample stream of the burst reader.
// Latency: none, this is wiring only.
// Backpressure: out_ready flows from the consumer back to the reader.
interface on_chip_mem_burst_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  // Reader side: drives RAM requests and the sample stream.
  modport master (
    output mem_address, mem_chipselect, mem_clken, mem_write,
    input  mem_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  // RAM / consumer side.
  modport slave (
    input  mem_address, mem_chipselect, mem_clken, mem_write,
    output mem_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/on_chip_mem_burst_reader.sv
// Streams `length` samples from capture RAM starting at start_addr, wrapping at DEPTH.
// Latency: first out_valid RD_LATENCY+1 edges after start acceptance, then one sample per cycle.
// Backpressure: out_ready stalls the stream; RAM requests are credit-limited by FIFO room, so nothing is dropped.
// Optional: ON_CHIP_MEM_BURST_READER_DECIMATE_EN adds a `decim` address-step input.
module on_chip_mem_burst_reader #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 131072,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
`ifdef ON_CHIP_MEM_BURST_READER_DECIMATE_EN
  input  logic [ADDR_W-1:0] decim,
`endif
  output logic              busy,
  output logic              done,
  on_chip_mem_burst_reader_if.master bus
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic [ADDR_W:0]       req_rem_q, req_rem_d;
  logic [ADDR_W:0]       out_rem_q, out_rem_d;
  logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     fifo_mem_q [FIFO_DEPTH];

  logic [ADDR_W-1:0]     step;
  logic                  push, pop, credit_ok;
  logic [OCC_W-1:0]      occ;
  logic [ADDR_W:0]       addr_sum;
  logic [ADDR_W-1:0]     addr_nxt;

`ifdef ON_CHIP_MEM_BURST_READER_DECIMATE_EN
  logic [ADDR_W-1:0]     step_q, step_d;
  assign step = step_q;
`else
  assign step = ADDR_W'(1);
`endif

  // FIFO handshake, outstanding-sample credit and the next modulo-DEPTH address.
  always_comb begin
    push = vld_sr_q[RD_LATENCY-1];
    pop  = (cnt_q != '0) && bus.out_ready;
    occ  = OCC_W'(cnt_q) + OCC_W'(cs_q);
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + OCC_W'(vld_sr_q[i]);
    // A pop this cycle frees a slot, so it is credited before the room check.
    credit_ok = (occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);
    addr_sum  = {1'b0, addr_q} + {1'b0, step};
    if (addr_sum >= DEPTH_W) addr_sum = addr_sum - DEPTH_W;
    addr_nxt  = addr_sum[ADDR_W-1:0];
  end

  // Block FSM: accepts start, issues exactly `length` requests, waits for the last beat.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cs_d      = 1'b0;
    req_rem_d = req_rem_q;
    out_rem_d = pop ? (out_rem_q - ONE_W) : out_rem_q;
`ifdef ON_CHIP_MEM_BURST_READER_DECIMATE_EN
    step_d    = step_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_rem_d = length;
          req_rem_d = length;
`ifdef ON_CHIP_MEM_BURST_READER_DECIMATE_EN
          step_d    = (decim == '0) ? ADDR_W'(1) : decim;
`endif
          if (length == '0) begin
            state_d = S_FINISH;
          end else begin
            // First request goes out registered in the cycle after acceptance.
            state_d   = S_READ;
            cs_d      = 1'b1;
            addr_d    = start_addr;
            req_rem_d = length - ONE_W;
          end
        end
      end
      S_READ: begin
        if (req_rem_q == '0) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          cs_d      = 1'b1;
          addr_d    = addr_nxt;
          req_rem_d = req_rem_q - ONE_W;
          if (req_rem_q == ONE_W) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (out_rem_q == ONE_W)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Latency tag shift register and FIFO pointer/count updates.
  always_comb begin
    vld_sr_d    = '0;
    vld_sr_d[0] = cs_q;
    for (int i = 1; i < RD_LATENCY; i++) vld_sr_d[i] = vld_sr_q[i-1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state; reset aborts a block and drops everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      req_rem_q <= '0;
      out_rem_q <= '0;
      vld_sr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      req_rem_q <= req_rem_d;
      out_rem_q <= out_rem_d;
      vld_sr_q  <= vld_sr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef ON_CHIP_MEM_BURST_READER_DECIMATE_EN
  // Address step latched at block start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step_q <= ADDR_W'(1);
    else          step_q <= step_d;
  end
`endif

  // FIFO storage; contents are only visible through the count-qualified head.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.mem_readdata;
  end

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_write      = 1'b0;
  assign bus.out_valid      = (cnt_q != '0);
  assign bus.out_data       = (cnt_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
  assign bus.out_last       = (cnt_q != '0) && (out_rem_q == ONE_W);
  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_FINISH);

endmodule

// File: doc/on_chip_mem_burst_reader.md
Name: on_chip_mem_burst_reader

Overview:
- Parametrised successor to the single-address on-chip memory read adapter.
- On a start pulse, reads a block of LENGTH samples from on-chip capture RAM, beginning at a trigger-relative start address.
- Handles wrap-around at DEPTH and a configurable RAM read latency.
- Delivers samples on a valid/ready stream with backpressure and an end-of-block marker. Sits between the capture RAM and the display/HPS transfer logic.

Parameters:
- ADDR_W, 17, memory address width.
- DATA_W, 16, sample width.
- DEPTH, 131072, buffer size in words; must be ≤ 2^ADDR_W and ≥ 2.
- RD_LATENCY, 2, cycles from a request being sampled by RAM to mem_readdata valid; range 1..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a block read.
- start_addr  in  ADDR_W  first address; must be < DEPTH.
- length  in  ADDR_W+1  sample count; range 0..DEPTH.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at block completion.
- mem_address  out  ADDR_W  RAM address, registered.
- mem_chipselect  out  1  read request qualifier, registered.
- mem_clken  out  1  constant 1.
- mem_write  out  1  constant 0.
- mem_readdata  in  DATA_W  RAM read data.
- out_data  out  DATA_W  sample.
- out_valid  out  1  sample available.
- out_ready  in  1  consumer accepts when high with out_valid.
- out_last  out  1  high with the final sample of a block.

Behaviour:
- Clock and reset: one clock `clk`; asynchronous active-low reset `reset_n`.
- Reset values:
  - state = IDLE.
  - busy = done = mem_chipselect = out_valid = out_last = 0.
  - mem_address = 0; out_data = 0.
  - FIFO empty; in-flight pipeline cleared.
  - mem_clken = 1 and mem_write = 0 at all times, including during reset.
- Reset mid-block: aborts immediately. In-flight read data is discarded, and no done pulse is produced.
- States:
  - IDLE → READ: on start with length ≠ 0.
  - IDLE → FINISH: on start with length = 0.
  - READ → DRAIN: after the final request is issued.
  - DRAIN → FINISH: after the out_last beat is accepted.
  - FINISH → IDLE: unconditional. done = 1 for exactly this cycle.
- start handling:
  - start is sampled only in IDLE; it is ignored while busy.
  - busy is set on the edge that accepts start and cleared on FINISH→IDLE.
- Read issue:
  - The first request is presented in the cycle after the accepting edge (mem_chipselect = 1, mem_address = start_addr).
  - Each further request increments the address by 1 and wraps from DEPTH-1 to 0, not 2^ADDR_W-1.
  - Exactly `length` requests are issued per block; mem_chipselect is 0 whenever no request is issued.
- Latency tracking:
  - A RD_LATENCY-deep valid shift register tracks issued requests.
  - mem_readdata is pushed into the output FIFO on the edge where the matching tag exits the shift register.
- Output FIFO and flow control:
  - Show-ahead FIFO of depth ≥ RD_LATENCY+2.
  - A request is issued only if (in-flight count + FIFO count) < FIFO depth. A pop in the same cycle may be credited.
  - Samples are never dropped or duplicated under any out_ready pattern.
- Throughput:
  - With out_ready held 1, the first out_valid follows the accepting edge by RD_LATENCY+1 edges.
  - After that, one sample per cycle with no bubbles.
- Stream rules:
  - out_data and out_valid hold stable while out_valid = 1 and out_ready = 0.
  - out_last is asserted only with the length-th sample.
- Counters: the remaining-request and remaining-output counters are ADDR_W+1 bits, so length = DEPTH is legal.
  - With length = DEPTH, every address is read exactly once, starting at start_addr.

Optional Feature:
- Macro: ON_CHIP_MEM_BURST_READER_DECIMATE_EN (timebase decimation).
- When defined:
  - Adds input `decim` [ADDR_W-1:0], sampled at start acceptance; value 0 is treated as 1.
  - The address step is decim instead of 1, with modulo-DEPTH wrap (addr + decim − DEPTH when the sum ≥ DEPTH).
  - `length` still counts output samples.
- When undefined: no port is added and the step is fixed at 1.

Test Plan:
- Basic latency and contiguity: RD_LATENCY = 2; start_addr = 100; length = 4; out_ready = 1.
  - Requests on addresses 100..103 on consecutive cycles.
  - First out_valid 3 edges after start acceptance; 4 contiguous beats; out_last on beat 4; done one cycle after, then busy = 0.
- Wrap-around: DEPTH = 16 (test parameter); start_addr = 14; length = 5.
  - Addresses 14, 15, 0, 1, 2; data matches the RAM model in order.
- Backpressure: length = 20; out_ready toggles randomly at 30% high.
  - All 20 samples delivered in order with no loss or duplication.
  - FIFO never overflows; out_data stays stable while stalled.
- Zero length and ignored start:
  - length = 0 → no mem_chipselect, done pulse 1 cycle after accept.
  - A second start during a block is ignored: request count is unchanged.
- Reset mid-operation: assert reset_n = 0 while in READ with samples in flight.
  - All outputs return to reset values immediately; no done pulse.
  - A fresh start afterwards reads the correct block.
- Decimation (macro defined): DEPTH = 16; start_addr = 10; decim = 3; length = 4.
  - Addresses 10, 13, 0, 3; decim = 0 behaves as step 1.
